sum_bcd_display: RTL and testbench
==================================

SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 The block SHALL have a parameter REFRESH_DIV, default 50000, giving the number of clk cycles each digit is displayed; legal range 2..2^20.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge system clock; sole clock of the block.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 sum_in  input  5  unsigned sum from the upstream 4-bit carry-lookahead adder (out[4:0]), values 0..31.
REQ-006 sum_valid  input  1  sum_in is valid this cycle.
REQ-007 sum_ready  output  1  block can accept sum_in this cycle.
REQ-008 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 an  output  2  active-low digit enables: an[0] selects units, an[1] selects tens.

Function
REQ-010 A transfer SHALL occur on a rising edge where sum_valid=1 and sum_ready=1; sum_in SHALL be captured into a 5-bit remainder register and the tens counter cleared.
REQ-011 FSM states SHALL be IDLE and CONVERT; sum_ready SHALL be 1 exactly when the state is IDLE (Moore output, no combinational path from sum_valid).
REQ-012 IDLE -> CONVERT on a transfer edge; IDLE holds otherwise.
REQ-013 In CONVERT, each edge with remainder >= 10 SHALL subtract 10 from the remainder and add 1 to the 2-bit tens counter.
REQ-014 In CONVERT, the edge with remainder < 10 SHALL load tens into the displayed-tens register and the remainder[3:0] into the displayed-units register, then go to IDLE.
REQ-015 Latency: for an input with t tens (t = 0..3), displayed digits SHALL update at edge E0+t+1, where E0 is the transfer edge; sum_ready SHALL be 0 for t+1 cycles.
REQ-016 sum_valid while in CONVERT SHALL be ignored; upstream holds data until sum_ready=1.
REQ-017 Displayed registers SHALL hold their value between conversions.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap edge the digit select SHALL toggle.
REQ-019 Digit select 0 SHALL drive an=2'b10 with the units pattern; select 1 SHALL drive an=2'b01 with the tens pattern.
REQ-020 Segment patterns for 0..9 SHALL be standard active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 Leading-zero blanking: when displayed tens = 0, the tens slot SHALL output seg=1111111.
REQ-022 seg and an SHALL be registered outputs, updating one edge after the select or digit change.
REQ-023 All 5-bit inputs 0..31 SHALL convert correctly; there are no error states.

Reset
REQ-024 When rst=1 on an edge: state=IDLE, remainder=0, tens counter=0, displayed digits=0, refresh counter=0, digit select=0.
REQ-025 The first edge with rst=1 SHALL set the outputs to sum_ready=1, an=2'b10, seg=1000000.
REQ-026 rst during CONVERT SHALL abort the conversion, with no display update from the aborted value.
REQ-027 rst SHALL have priority over a simultaneous transfer; that transfer is dropped.

Verification (REFRESH_DIV=4 for simulation)
REQ-028 Reset scenario: hold rst for 2 cycles, then release -> sum_ready=1, an=10, seg=1000000; an toggles to 01 with seg=1111111 after 4 cycles.
REQ-029 Single-digit scenario: send sum_in=7 -> sum_ready low for 1 cycle; the units slot shows 1111000 and the tens slot is blank.
REQ-030 Maximum-value scenario: send sum_in=30, representing 15+15 -> sum_ready low for 4 cycles; tens slot shows 0110000 and units slot shows 1000000.
REQ-031 Back-to-back scenario: hold sum_valid=1 with 12, then 25 -> 12 is accepted, 25 waits until sum_ready=1, and the display ends at 2/5 with no dropped or duplicated transfer.
REQ-032 Mid-operation reset scenario: send 31, then assert rst on the second CONVERT cycle -> the display returns to 0 and 31 is never shown.
REQ-033 Boundary scenario: send sum_in=10, then sum_in=9 -> the display shows 1/0 (tens 1111001), then 9 with the tens slot blanked.

Source files
------------

// File: rtl/sum_bcd_display.sv
// Converts a 0..31 adder sum to two BCD digits by repeated subtraction and
// drives a time-multiplexed, active-low two-digit seven-segment display.
module sum_bcd_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       sum_ready,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned SUM_W   = 5;
  localparam int unsigned TENS_W  = 2;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   rem_q, rem_d;
  logic [TENS_W-1:0]  tens_q, tens_d;
  logic [TENS_W-1:0]  tens_disp_q;
  logic [DIGIT_W-1:0] units_disp_q;
  logic               load;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic [SEG_W-1:0]   seg_d;
  logic [1:0]         an_d;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Conversion FSM: one subtract-by-ten per cycle, load display when remainder < 10
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sum_valid) begin
          state_d = CONVERT;
          rem_d   = sum_in;
          tens_d  = '0;
        end
      end
      CONVERT: begin
        if (rem_q >= SUM_W'(10)) begin
          rem_d  = rem_q - SUM_W'(10);
          tens_d = tens_q + TENS_W'(1);
        end else begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh divider, digit select and segment/anode drive
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    sel_d = sel_q ^ (cnt_q == CNT_MAX);
    if (!sel_q) begin
      an_d  = 2'b10;
      seg_d = seg_decode(units_disp_q);
    end else begin
      an_d  = 2'b01;
      seg_d = (tens_disp_q == '0) ? SEG_BLANK : seg_decode(DIGIT_W'(tens_disp_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      tens_q       <= '0;
      tens_disp_q  <= '0;
      units_disp_q <= '0;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      sum_ready    <= 1'b1;
      an           <= 2'b10;
      seg          <= 7'b1000000;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tens_q    <= tens_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sum_ready <= (state_d == IDLE);
      an        <= an_d;
      seg       <= seg_d;
      if (load) begin
        tens_disp_q  <= tens_q;
        units_disp_q <= rem_q[DIGIT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: reset, latency, blanking, back-to-back
// transfers and mid-conversion reset, with hand-computed segment patterns.
module tb_sum_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum_in;
  logic       sum_valid;
  logic       sum_ready;
  logic [6:0] seg;
  logic [1:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  sum_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a value and complete the transfer edge once sum_ready is seen
  task automatic start(input logic [4:0] v);
    int n;
    n = 0;
    sum_valid = 1'b1;
    sum_in    = v;
    while (!sum_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    sum_valid = 1'b0;
  endtask

  // Count cycles with sum_ready low after a transfer edge
  task automatic wait_ready(input string tag, input int exp_low);
    int n;
    n = 0;
    while (!sum_ready && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, exp_low);
  endtask

  // Sample both digit slots over a full refresh period
  task automatic show(input string tag, input logic [6:0] eu, input logic [6:0] et);
    logic [6:0] u, t;
    logic gu, gt;
    u = '0; t = '0; gu = 1'b0; gt = 1'b0;
    tick();
    for (int i = 0; i < 20 && !(gu && gt); i++) begin
      if (an == 2'b10) begin u = seg; gu = 1'b1; end
      else if (an == 2'b01) begin t = seg; gt = 1'b1; end
      tick();
    end
    check({tag, "_slots_seen"}, {gu, gt}, 2'b11);
    check({tag, "_units"}, u, eu);
    check({tag, "_tens"}, t, et);
  endtask

  initial begin
    rst = 1'b1; sum_valid = 1'b0; sum_in = '0;
    tick();
    check("rst_ready", sum_ready, 1'b1);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, S0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("refresh_an_before", an, 2'b10);
    tick();
    check("refresh_an_toggle", an, 2'b01);
    check("refresh_tens_blank", seg, SB);

    start(5'd7);
    wait_ready("lat_7", 1);
    show("d7", S7, SB);

    start(5'd30);
    wait_ready("lat_30", 4);
    show("d30", S0, S3);

    // Hold valid across both transfers; 25 must wait for sum_ready
    sum_valid = 1'b1; sum_in = 5'd12;
    tick();
    check("b2b_busy", sum_ready, 1'b0);
    sum_in = 5'd25;
    wait_ready("lat_12", 2);
    tick();
    sum_valid = 1'b0;
    wait_ready("lat_25", 3);
    tick();
    check("b2b_no_dup", sum_ready, 1'b1);
    show("d25", S5, S2);

    start(5'd10);
    wait_ready("lat_10", 2);
    show("d10", S0, S1);
    start(5'd9);
    wait_ready("lat_9", 1);
    show("d9", S9, SB);

    start(5'd31);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", sum_ready, 1'b1);
    check("abort_an", an, 2'b10);
    check("abort_seg", seg, S0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_idle", sum_ready, 1'b1);
    show("d_abort", S0, SB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
